// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared widths, the ALU request payload struct and the arbiter FSM state
// encoding used by alu_arbiter and alu_arb_tag_fifo.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

    localparam int OP_WIDTH     = 3;
    localparam int DATA_WIDTH   = 8;
    localparam int RESULT_WIDTH = 16;

    // One ALU request: opcode plus two operands.
    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
    } alu_req_t;

    // ARB_IDLE: no grant held, arbitration runs combinationally every cycle.
    // ARB_GRANTED: a winner has been latched and waits for the ALU to accept.
    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_GRANTED = 1'b1
    } arb_state_e;

endpackage : alu_arb_pkg

// File: rtl/alu_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// alu_arb_tag_fifo
// Synchronous FIFO of requester tags for ALU transactions in flight. A tag is
// pushed when the ALU accepts a request and popped when the ALU response is
// handed back, so the head always names the requester owed the next response.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   push_i        write push_tag_i (ignored while full)
//   push_tag_i    requester index of the request just accepted
//   pop_i         drop the head entry (ignored while empty)
//   head_tag_o    requester index at the head of the FIFO
//   full_o        count == DEPTH
//   empty_o       count == 0
//   count_o       number of tags held
// -----------------------------------------------------------------------------
module alu_arb_tag_fifo
    import alu_arb_pkg::*;
#(
    parameter int TAG_W = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [TAG_W-1:0]         push_tag_i,
    input  logic                     pop_i,
    output logic [TAG_W-1:0]         head_tag_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_tag_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two; the count is
    // kept as its own register so full and empty are never ambiguous.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

endmodule : alu_arb_tag_fifo

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one pipelined ALU between NUM_REQ requesters. Requests are picked
// round-robin and forwarded to the ALU; the winner's index is queued in a tag
// FIFO so in-order ALU responses can be routed back to the right requester.
//
// Handshake rule on every port: a transfer happens on a rising clk edge where
// valid and ready are both high. A valid, once raised by this block, stays
// high with stable payload until the transfer.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   up_req_valid/ready    per-requester request handshake
//   up_req_op/op1/op2     per-requester request payload
//   up_resp_valid/ready   per-requester response handshake
//   up_resp_result        shared response data (valid where up_resp_valid set)
//   req_valid/ready       ALU request handshake
//   req_op/op1/op2        ALU request payload
//   resp_valid/ready      ALU response handshake
//   resp_result           ALU response data
//   outstanding           ALU transactions in flight
//   err_unexpected_resp   sticky: ALU responded with nothing in flight
//   dbg_state             arbiter FSM state (0 idle, 1 granted)
//   dbg_rr_ptr            round-robin search start index
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic [NUM_REQ-1:0]                    up_req_valid,
    output logic [NUM_REQ-1:0]                    up_req_ready,
    input  logic [NUM_REQ-1:0][OP_WIDTH-1:0]      up_req_op,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    up_req_op1,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    up_req_op2,

    output logic [NUM_REQ-1:0]                    up_resp_valid,
    input  logic [NUM_REQ-1:0]                    up_resp_ready,
    output logic [RESULT_WIDTH-1:0]               up_resp_result,

    output logic                                  req_valid,
    input  logic                                  req_ready,
    output logic [OP_WIDTH-1:0]                   req_op,
    output logic [DATA_WIDTH-1:0]                 req_op1,
    output logic [DATA_WIDTH-1:0]                 req_op2,

    input  logic                                  resp_valid,
    output logic                                  resp_ready,
    input  logic [RESULT_WIDTH-1:0]               resp_result,

    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding,
    output logic                                  err_unexpected_resp,
    output logic                                  dbg_state,
    output logic [$clog2(NUM_REQ)-1:0]            dbg_rr_ptr
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    alu_req_t         payload_q, payload_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;

    // Round-robin search result.
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Grant/payload presented to the ALU this cycle.
    logic [IDX_W-1:0] cur_grant;
    alu_req_t         cur_payload;
    logic             cur_valid;
    logic             req_fire;

    // Tag FIFO hookup.
    logic             fifo_push;
    logic             fifo_pop;
    logic [IDX_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    alu_arb_tag_fifo #(
        .TAG_W (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .push_tag_i (cur_grant),
        .pop_i      (fifo_pop),
        .head_tag_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!arb_found && up_req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Request path and arbiter FSM. In IDLE the search result goes straight
    // to the ALU so a back-to-back stream costs no bubbles; only when the ALU
    // does not take it that cycle is the winner latched and held in GRANTED.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        payload_d    = payload_q;
        rr_ptr_d     = rr_ptr_q;
        cur_grant    = grant_q;
        cur_payload  = payload_q;
        cur_valid    = 1'b0;
        req_valid    = 1'b0;
        req_fire     = 1'b0;
        up_req_ready = '0;

        case (state_q)
            ARB_IDLE: begin
                cur_grant       = arb_idx;
                cur_payload.op  = up_req_op[arb_idx];
                cur_payload.op1 = up_req_op1[arb_idx];
                cur_payload.op2 = up_req_op2[arb_idx];
                cur_valid       = arb_found;
            end
            ARB_GRANTED: begin
                // The latched request is issued even if its owner has since
                // dropped valid: the grant is committed.
                cur_valid = 1'b1;
            end
            default: begin
                cur_valid = 1'b0;
            end
        endcase

        // A full tag FIFO blocks issue even if a pop lands this cycle.
        req_valid = cur_valid & ~fifo_full & ~rst;
        req_fire  = req_valid & req_ready;

        if (req_fire) begin
            up_req_ready[cur_grant] = 1'b1;
            rr_ptr_d = (cur_grant == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : cur_grant + IDX_W'(1);
            state_d  = ARB_IDLE;
        end else if (state_q == ARB_IDLE && arb_found) begin
            state_d   = ARB_GRANTED;
            grant_d   = arb_idx;
            payload_d = cur_payload;
        end
    end

    assign req_op    = cur_payload.op;
    assign req_op1   = cur_payload.op1;
    assign req_op2   = cur_payload.op2;
    assign fifo_push = req_fire;

    // Response path: the FIFO head names the owner of the next response.
    // With nothing in flight the ALU response is drained and flagged.
    always_comb begin
        up_resp_valid = '0;
        resp_ready    = 1'b0;
        if (!rst) begin
            if (fifo_empty) begin
                resp_ready = 1'b1;
            end else begin
                resp_ready               = up_resp_ready[fifo_head];
                up_resp_valid[fifo_head] = resp_valid;
            end
        end
    end

    assign up_resp_result = resp_result;
    assign fifo_pop       = resp_valid & resp_ready & ~fifo_empty;
    assign err_d          = err_q | (resp_valid & fifo_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            payload_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            payload_q <= payload_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    assign outstanding         = fifo_count;
    assign err_unexpected_resp = err_q;
    assign dbg_state           = state_q;
    assign dbg_rr_ptr          = rr_ptr_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NUM_REQ = 4, MAX_OUTSTANDING = 4).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_alu_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       up_req_valid;
    logic [3:0]       up_req_ready;
    logic [3:0][2:0]  up_req_op;
    logic [3:0][7:0]  up_req_op1;
    logic [3:0][7:0]  up_req_op2;
    logic [3:0]       up_resp_valid;
    logic [3:0]       up_resp_ready;
    logic [15:0]      up_resp_result;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [7:0]       req_op1;
    logic [7:0]       req_op2;
    logic             resp_valid;
    logic             resp_ready;
    logic [15:0]      resp_result;
    logic [2:0]       outstanding;
    logic             err_unexpected_resp;
    logic             dbg_state;
    logic [1:0]       dbg_rr_ptr;

    int n_cmp = 0;
    int n_err = 0;

    alu_arbiter #(
        .NUM_REQ         (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .up_req_valid        (up_req_valid),
        .up_req_ready        (up_req_ready),
        .up_req_op           (up_req_op),
        .up_req_op1          (up_req_op1),
        .up_req_op2          (up_req_op2),
        .up_resp_valid       (up_resp_valid),
        .up_resp_ready       (up_resp_ready),
        .up_resp_result      (up_resp_result),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_op              (req_op),
        .req_op1             (req_op1),
        .req_op2             (req_op2),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_result         (resp_result),
        .outstanding         (outstanding),
        .err_unexpected_resp (err_unexpected_resp),
        .dbg_state           (dbg_state),
        .dbg_rr_ptr          (dbg_rr_ptr)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        rst           = 1'b1;
        up_req_valid  = 4'hF;
        up_resp_ready = 4'hF;
        req_ready     = 1'b1;
        resp_valid    = 1'b1;
        resp_result   = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            up_req_op[i]  = 3'(i);
            up_req_op1[i] = 8'h10 + 8'(i);
            up_req_op2[i] = 8'h20 + 8'(i);
        end
        #3;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_resp_ready", resp_ready, 0);
        chk("rst_up_req_ready", up_req_ready, 0);
        chk("rst_up_resp_valid", up_resp_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexpected_resp, 0);
        tick();
        tick();
        rst          = 1'b0;
        up_req_valid = 4'h0;
        resp_valid   = 1'b0;
        req_ready    = 1'b0;
        #1;
        chk("idle_req_valid", req_valid, 0);
        chk("idle_rr_ptr", dbg_rr_ptr, 0);

        // ---------- round robin stream: grants 0,1,2,3,0 ----------
        up_req_valid = 4'hF;
        req_ready    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                tick();
                resp_valid  = 1'b1;
                resp_result = 16'h0100 + 16'(i);
            end
            #1;
            chk("rr_req_valid", req_valid, 1);
            chk("rr_grant", up_req_ready, 32'(4'b0001 << (i % 4)));
            chk("rr_op", req_op, i % 4);
            chk("rr_op2", req_op2, 8'h20 + (i % 4));
            chk("rr_outstanding", outstanding, (i == 0) ? 0 : 1);
            if (i > 0) begin
                chk("rr_resp_route", up_resp_valid, 32'(4'b0001 << ((i - 1) % 4)));
                chk("rr_resp_result", up_resp_result, 16'h0100 + 16'(i));
            end
        end
        tick();
        up_req_valid = 4'h0;
        #1;
        chk("rr_stop_req_valid", req_valid, 0);
        chk("rr_tail_route", up_resp_valid, 4'b0001);
        chk("rr_tail_outstanding", outstanding, 1);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("rr_drained", outstanding, 0);
        chk("rr_no_err", err_unexpected_resp, 0);
        chk("rr_ptr_after", dbg_rr_ptr, 1);
        tick();
        #1;
        chk("noreq_rr_ptr_hold", dbg_rr_ptr, 1);
        chk("noreq_req_valid", req_valid, 0);

        // ---------- sticky grant: requester 2, ALU stalls 3 cycles ----------
        req_ready    = 1'b0;
        up_req_valid = 4'b0100;
        #1;
        chk("stall1_req_valid", req_valid, 1);
        chk("stall1_op", req_op, 2);
        chk("stall1_op1", req_op1, 8'h12);
        chk("stall1_up_ready", up_req_ready, 0);
        tick();
        up_req_op1[2] = 8'h99;   // owner changes payload mid-handshake
        up_req_valid  = 4'b0101; // and requester 0 joins
        #1;
        chk("stall2_req_valid", req_valid, 1);
        chk("stall2_op1_held", req_op1, 8'h12);
        chk("stall2_up_ready", up_req_ready, 0);
        chk("stall2_state", dbg_state, 1);
        tick();
        #1;
        chk("stall3_req_valid", req_valid, 1);
        chk("stall3_op1_held", req_op1, 8'h12);
        chk("stall3_up_ready", up_req_ready, 0);
        tick();
        req_ready = 1'b1;
        #1;
        chk("stall4_grant", up_req_ready, 4'b0100);
        chk("stall4_op", req_op, 2);
        chk("stall4_op1", req_op1, 8'h12);
        tick();
        up_req_op1[2] = 8'h12;
        up_req_valid  = 4'h0;
        req_ready     = 1'b0;
        #1;
        chk("stall_done_outstanding", outstanding, 1);
        chk("stall_done_rr_ptr", dbg_rr_ptr, 3);
        chk("stall_done_state", dbg_state, 0);
        resp_valid    = 1'b1;
        resp_result   = 16'h1234;
        up_resp_ready = 4'b0100;
        #1;
        chk("stall_resp_route", up_resp_valid, 4'b0100);
        chk("stall_resp_ready", resp_ready, 1);
        chk("stall_resp_result", up_resp_result, 16'h1234);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("stall_resp_drained", outstanding, 0);

        // ---------- fill the tag FIFO with 0,1,2,3 ----------
        req_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            up_req_valid = 4'(1 << j);
            #1;
            chk("fill_grant", up_req_ready, 32'(1 << j));
            tick();
        end
        up_req_valid = 4'b0001;
        #1;
        chk("full_outstanding", outstanding, 4);
        chk("full_req_valid", req_valid, 0);
        tick();
        #1;
        chk("full_state", dbg_state, 1);
        chk("full_req_valid2", req_valid, 0);
        resp_valid    = 1'b1;
        resp_result   = 16'h0042;
        up_resp_ready = 4'hF;
        #1;
        chk("full_pop_route", up_resp_valid, 4'b0001);
        chk("full_pop_resp_ready", resp_ready, 1);
        chk("full_no_bypass", req_valid, 0);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("after_pop_outstanding", outstanding, 3);
        chk("after_pop_req_valid", req_valid, 1);
        chk("after_pop_grant", up_req_ready, 4'b0001);
        tick();
        up_req_valid = 4'h0;
        #1;
        chk("refill_outstanding", outstanding, 4);

        // ---------- response backpressure: head tag 1, result BEEF ----------
        resp_valid    = 1'b1;
        resp_result   = 16'hBEEF;
        up_resp_ready = 4'b1101;
        #1;
        chk("bp1_route", up_resp_valid, 4'b0010);
        chk("bp1_resp_ready", resp_ready, 0);
        chk("bp1_result", up_resp_result, 16'hBEEF);
        tick();
        #1;
        chk("bp2_route", up_resp_valid, 4'b0010);
        chk("bp2_resp_ready", resp_ready, 0);
        chk("bp2_outstanding", outstanding, 4);
        tick();
        up_resp_ready = 4'b0010;
        #1;
        chk("bp3_route", up_resp_valid, 4'b0010);
        chk("bp3_resp_ready", resp_ready, 1);
        chk("bp3_result", up_resp_result, 16'hBEEF);
        tick();
        up_resp_ready = 4'hF;
        #1;
        chk("bp_done_outstanding", outstanding, 3);
        chk("drain_route_2", up_resp_valid, 4'b0100);
        tick();
        #1;
        chk("drain_route_3", up_resp_valid, 4'b1000);
        tick();
        #1;
        chk("drain_route_0", up_resp_valid, 4'b0001);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("drain_outstanding", outstanding, 0);
        chk("drain_no_err", err_unexpected_resp, 0);

        // ---------- unexpected response ----------
        resp_valid = 1'b1;
        #1;
        chk("unexp_resp_ready", resp_ready, 1);
        chk("unexp_no_route", up_resp_valid, 0);
        tick();
        resp_valid = 1'b0;
        #1;
        chk("unexp_err_set", err_unexpected_resp, 1);
        chk("unexp_outstanding", outstanding, 0);
        tick();
        tick();
        #1;
        chk("unexp_err_sticky", err_unexpected_resp, 1);

        // ---------- reset with two in flight ----------
        up_req_valid = 4'b0010;
        #1;
        chk("pre_rst_grant1", up_req_ready, 4'b0010);
        tick();
        up_req_valid = 4'b0100;
        #1;
        chk("pre_rst_grant2", up_req_ready, 4'b0100);
        tick();
        up_req_valid = 4'hF;
        #1;
        chk("pre_rst_outstanding", outstanding, 2);
        chk("pre_rst_rr_ptr", dbg_rr_ptr, 3);
        resp_valid = 1'b1;
        rst        = 1'b1;
        #1;
        chk("mid_rst_req_valid", req_valid, 0);
        chk("mid_rst_up_req_ready", up_req_ready, 0);
        chk("mid_rst_resp_ready", resp_ready, 0);
        chk("mid_rst_up_resp_valid", up_resp_valid, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_rr_ptr", dbg_rr_ptr, 0);
        chk("mid_rst_err", err_unexpected_resp, 0);
        tick();
        rst          = 1'b0;
        up_req_valid = 4'h0;
        #1;
        chk("post_rst_stale_ready", resp_ready, 1);
        chk("post_rst_stale_route", up_resp_valid, 0);
        tick();
        resp_valid   = 1'b0;
        up_req_valid = 4'b0110;
        #1;
        chk("post_rst_stale_err", err_unexpected_resp, 1);
        chk("post_rst_grant", up_req_ready, 4'b0010);
        chk("post_rst_op", req_op, 1);
        tick();
        up_req_valid = 4'h0;
        #1;
        chk("post_rst_outstanding", outstanding, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu_arbiter
